// File: rtl/bin_truth_table_sweeper.sv
// bin_truth_table_sweeper: drives every input vector into a combinational circuit,
// waits SETTLE cycles, captures io_out and streams (vector, result) records.
module bin_truth_table_sweeper #(
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [IN_W-1:0]  rec_vec,
    output logic [OUT_W-1:0] rec_result,
    output logic             rec_last
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT, S_DONE} state_t;
    localparam logic [IN_W-1:0] LAST_VEC = '1;
    localparam logic [7:0] RELOAD = 8'(SETTLE - 1);
    state_t r_state;
    state_t w_next;
    logic [7:0] r_cnt;
    logic [IN_W-1:0] r_dut_in;
    logic [IN_W-1:0] r_vec;
    logic [OUT_W-1:0] r_result;
    logic r_last;
    logic r_valid;
    logic r_busy;
    logic r_done;
    logic w_launch;
    logic w_capture;
    logic w_step;
    always_ff @(posedge clk) begin
        r_state <= rst ? S_IDLE : w_next;
    end
    always_comb begin
        w_next = (r_state == S_IDLE)  ? (start ? S_DRIVE : S_IDLE) :
                 (r_state == S_DRIVE) ? ((r_cnt == '0) ? S_EMIT : S_DRIVE) :
                 (r_state == S_EMIT)  ? (rec_ready ? (r_last ? S_DONE : S_DRIVE) : S_EMIT) :
                                        S_IDLE;
    end
    always_comb begin
        w_launch  = (r_state == S_IDLE) && start;
        w_capture = (r_state == S_DRIVE) && (r_cnt == '0);
        w_step    = (r_state == S_EMIT) && rec_ready && !r_last;
    end
    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dut_in <= '0;
            r_vec    <= '0;
            r_result <= '0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy  <= (w_next == S_DRIVE) || (w_next == S_EMIT);
            r_done  <= w_next == S_DONE;
            r_valid <= w_next == S_EMIT;
            if (w_launch) begin
                r_dut_in <= '0;
                r_cnt    <= RELOAD;
            end else if (w_step) begin
                r_dut_in <= r_dut_in + 1'b1;
                r_cnt    <= RELOAD;
            end else if (r_state == S_DRIVE) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_vec    <= r_dut_in;
                r_result <= dut_out;
                r_last   <= r_dut_in == LAST_VEC;
            end
        end
    end
    assign busy       = r_busy;
    assign done       = r_done;
    assign dut_in     = r_dut_in;
    assign rec_valid  = r_valid;
    assign rec_vec    = r_vec;
    assign rec_result = r_result;
    assign rec_last   = r_last;
endmodule

// File: tb/tb_bin_truth_table_sweeper.sv
// tb_bin_truth_table_sweeper: directed checks of the sweeper against an inverter
// circuit and against slow-settling circuit models at two SETTLE values.
module tb_bin_truth_table_sweeper;
    typedef struct {
        logic       st;
        logic       rd;
        logic [9:0] exp;
    } row_t;
    logic clk = 1'b0;
    logic rst, start, rec_ready, busy, done, rec_valid, rec_last;
    logic [1:0] dut_in, dut_out, rec_vec, rec_result;
    logic s_alt, rdy_alt;
    logic a4_busy, a4_done, a4_valid, a4_last, a2_busy, a2_done, a2_valid, a2_last;
    logic [1:0] a4_in, a4_out, a4_vec, a4_res, a2_in, a2_out, a2_vec, a2_res;
    logic [1:0] p4_1, p4_2, p4_3, p2_1, p2_2, p2_3;
    int checks = 0;
    int errors = 0;
    row_t tbl[10];
    logic [4:0] rec_tbl[4];
    logic [3:0] s4_tbl[4];
    logic [3:0] s2_tbl[4];

    always #5 clk = ~clk;

    function automatic logic [1:0] inv(input logic [1:0] v);
        return {v[1], ~v[0]};
    endfunction

    assign dut_out = inv(dut_in);
    // Slow circuit: output reflects the input from three cycles earlier.
    always @(posedge clk) begin
        p4_1 <= inv(a4_in); p4_2 <= p4_1; p4_3 <= p4_2;
        p2_1 <= inv(a2_in); p2_2 <= p2_1; p2_3 <= p2_2;
    end
    assign a4_out = p4_3;
    assign a2_out = p2_3;

    bin_truth_table_sweeper #(.IN_W(2), .OUT_W(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .dut_in(dut_in), .dut_out(dut_out), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_vec(rec_vec), .rec_result(rec_result), .rec_last(rec_last));
    bin_truth_table_sweeper #(.IN_W(2), .OUT_W(2), .SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(s_alt), .busy(a4_busy), .done(a4_done),
        .dut_in(a4_in), .dut_out(a4_out), .rec_valid(a4_valid), .rec_ready(rdy_alt),
        .rec_vec(a4_vec), .rec_result(a4_res), .rec_last(a4_last));
    bin_truth_table_sweeper #(.IN_W(2), .OUT_W(2), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(s_alt), .busy(a2_busy), .done(a2_done),
        .dut_in(a2_in), .dut_out(a2_out), .rec_valid(a2_valid), .rec_ready(rdy_alt),
        .rec_vec(a2_vec), .rec_result(a2_res), .rec_last(a2_last));

    function automatic logic [9:0] snap();
        return {rec_valid, rec_vec, rec_result, rec_last, busy, done, dut_in};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int sv, input int sn, input bit poke, input int dk);
        int k = 0;
        int st = 0;
        int n = 0;
        int kd = -1;
        start = 1'b1;
        rec_ready = 1'b1;
        tick();
        start = 1'b0;
        while (k < 100 && kd < 0) begin
            if (poke) start = k < 2;
            if (rec_valid && rec_vec == sv[1:0] && st < sn) begin
                rec_ready = 1'b0;
                st++;
                chk("stall_hold", {rec_valid, rec_vec, rec_result, dut_in},
                    {1'b1, sv[1:0], inv(sv[1:0]), sv[1:0]});
            end else begin
                rec_ready = 1'b1;
                if (rec_valid) begin
                    chk($sformatf("rec%0d", n), {rec_vec, rec_result, rec_last}, rec_tbl[n % 4]);
                    n++;
                end
            end
            if (done) kd = k;
            else begin
                tick();
                k++;
            end
        end
        start = 1'b0;
        chk("done_at", kd, dk);
        chk("nrec", n, 4);
        tick();
        chk("done_pulse", {done, busy}, 2'b00);
        tick();
        chk("no_restart", {busy, rec_valid}, 2'b00);
    endtask

    initial begin
        int k, n, n4, n2, k4, k2, d1, d2;
        tbl[0] = '{1'b1, 1'b1, 10'b0_00_00_0_1_0_00};
        tbl[1] = '{1'b0, 1'b1, 10'b1_00_01_0_1_0_00};
        tbl[2] = '{1'b0, 1'b1, 10'b0_00_01_0_1_0_01};
        tbl[3] = '{1'b0, 1'b1, 10'b1_01_00_0_1_0_01};
        tbl[4] = '{1'b0, 1'b1, 10'b0_01_00_0_1_0_10};
        tbl[5] = '{1'b0, 1'b1, 10'b1_10_11_0_1_0_10};
        tbl[6] = '{1'b0, 1'b1, 10'b0_10_11_0_1_0_11};
        tbl[7] = '{1'b0, 1'b1, 10'b1_11_10_1_1_0_11};
        tbl[8] = '{1'b0, 1'b1, 10'b0_11_10_1_0_1_11};
        tbl[9] = '{1'b0, 1'b1, 10'b0_11_10_1_0_0_11};
        rec_tbl = '{5'b00_01_0, 5'b01_00_0, 5'b10_11_0, 5'b11_10_1};
        s4_tbl = '{4'b00_01, 4'b01_00, 4'b10_11, 4'b11_10};
        s2_tbl = '{4'b00_01, 4'b01_01, 4'b10_00, 4'b11_11};
        rst = 1'b1; start = 1'b0; rec_ready = 1'b0; s_alt = 1'b0; rdy_alt = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle%0d", i), snap(), 10'd0);
        end
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st;
            rec_ready = tbl[i].rd;
            tick();
            chk($sformatf("row%0d", i), snap(), tbl[i].exp);
        end
        start = 1'b0;
        tick();
        sweep(1, 5, 1'b0, 13);
        sweep(-1, 0, 1'b1, 8);
        // start held high: back-to-back sweeps separated by the DONE cycle
        start = 1'b1;
        rec_ready = 1'b1;
        tick();
        k = 0; n = 0; d1 = -1; d2 = -1;
        while (k < 40 && d2 < 0) begin
            if (rec_valid) n++;
            if (done) begin
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
            if (d2 < 0) begin
                tick();
                k++;
            end
        end
        start = 1'b0;
        chk("held_d1", d1, 8);
        chk("held_d2", d2, 18);
        chk("held_nrec", n, 8);
        tick();
        tick();
        chk("held_idle", busy, 1'b0);
        // reset while a record is stalled
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < 20 && !(rec_valid && rec_vec == 2'd2)) begin
            tick();
            k++;
        end
        rec_ready = 1'b0;
        chk("mid_wait", k, 5);
        tick();
        tick();
        chk("mid_stall", {rec_valid, rec_vec, dut_in, busy}, {1'b1, 2'd2, 2'd2, 1'b1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", {rec_valid, dut_in, busy, done}, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_nodone", {done, busy, rec_valid}, 3'd0);
        end
        sweep(-1, 0, 1'b0, 8);
        // settle timing against the 3-cycle circuit
        s_alt = 1'b1;
        tick();
        s_alt = 1'b0;
        k = 0; n4 = 0; n2 = 0; k4 = -1; k2 = -1;
        while (k < 60 && (k4 < 0 || k2 < 0)) begin
            if (a4_valid) begin
                chk($sformatf("s4_rec%0d", n4), {a4_vec, a4_res}, s4_tbl[n4 % 4]);
                n4++;
            end
            if (a2_valid) begin
                chk($sformatf("s2_rec%0d", n2), {a2_vec, a2_res}, s2_tbl[n2 % 4]);
                n2++;
            end
            if (a4_done) k4 = k;
            if (a2_done) k2 = k;
            tick();
            k++;
        end
        chk("s4_nrec", n4, 4);
        chk("s2_nrec", n2, 4);
        chk("s4_done_at", k4, 20);
        chk("s2_done_at", k2, 12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
